mips_decode_exec: RTL and testbench

- Registered decode/execute slice for the five-stage MIPS pipeline.
- Combines three functions: a main opcode decoder (control signals), an ALU-control decoder (aluop + funct -> 4-bit ALU op), and a 32-bit ALU with a zero flag.
- All outputs are registered, with one-cycle latency.
- Sits at the ID/EX boundary. Forwarding muxes, immediate sign-extension and the alusrc mux are external; operand b arrives already selected.

---
 rtl/mips_decode_exec.sv | 132 +++++++++++++
 tb/tb_mips_decode_exec.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mips_decode_exec.sv
// ID/EX decode/execute slice: main control decode, ALU-control decode and a 32-bit ALU.
// All outputs are registered with one cycle of latency.
module mips_decode_exec #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bubble,
  output logic         regdst,
  output logic [1:0]   branch,
  output logic         memread,
  output logic         memwrite,
  output logic         memtoreg,
  output logic [1:0]   aluop,
  output logic         alusrc,
  output logic         regwrite,
  output logic [3:0]   aluctl,
  output logic [W-1:0] result,
  output logic         zero
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  // Control word order: regdst, branch[1:0], memread, memtoreg, aluop[1:0], memwrite, alusrc, regwrite
  logic [9:0]   ctl_c;
  logic [1:0]   aluop_c;
  logic [3:0]   aluctl_c;
  logic [W-1:0] result_c;

  logic [9:0]   ctl_d,    ctl_q;
  logic [3:0]   aluctl_d, aluctl_q;
  logic [W-1:0] result_d, result_q;
  logic         zero_d,   zero_q;

  always_comb begin
    ctl_c = 10'b0;
    unique case (opcode)
      OP_RTYPE: ctl_c = 10'b1_00_0_0_10_0_0_1;
      OP_LW:    ctl_c = 10'b0_00_1_1_00_0_1_1;
      OP_SW:    ctl_c = 10'b0_00_0_0_00_1_1_0;
      OP_BEQ:   ctl_c = 10'b0_01_0_0_01_0_0_0;
      OP_BNE:   ctl_c = 10'b0_10_0_0_01_0_0_0;
      OP_ADDI:  ctl_c = 10'b0_00_0_0_00_0_1_1;
      default:  ctl_c = 10'b0;
    endcase
  end

  // ALU control follows the unbubbled decode so the datapath keeps computing during stalls.
  assign aluop_c = ctl_c[4:3];

  always_comb begin
    aluctl_c = ALU_BAD;
    unique case (aluop_c)
      2'b00: aluctl_c = ALU_ADD;
      2'b01: aluctl_c = ALU_SUB;
      2'b10: begin
        unique case (funct)
          6'h20:   aluctl_c = ALU_ADD;
          6'h22:   aluctl_c = ALU_SUB;
          6'h24:   aluctl_c = ALU_AND;
          6'h25:   aluctl_c = ALU_OR;
          6'h27:   aluctl_c = ALU_NOR;
          6'h2A:   aluctl_c = ALU_SLT;
          default: aluctl_c = ALU_BAD;
        endcase
      end
      default: aluctl_c = ALU_BAD;
    endcase
  end

  always_comb begin
    result_c = '0;
    unique case (aluctl_c)
      ALU_AND: result_c = a & b;
      ALU_OR:  result_c = a | b;
      ALU_ADD: result_c = a + b;
      ALU_SUB: result_c = a - b;
      ALU_SLT: result_c = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: result_c = ~(a | b);
      default: result_c = '0;
    endcase
  end

  assign ctl_d    = bubble ? 10'b0 : ctl_c;
  assign aluctl_d = aluctl_c;
  assign result_d = result_c;
  assign zero_d   = (result_c == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_q    <= '0;
      aluctl_q <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      ctl_q    <= ctl_d;
      aluctl_q <= aluctl_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign regdst   = ctl_q[9];
  assign branch   = ctl_q[8:7];
  assign memread  = ctl_q[6];
  assign memtoreg = ctl_q[5];
  assign aluop    = ctl_q[4:3];
  assign memwrite = ctl_q[2];
  assign alusrc   = ctl_q[1];
  assign regwrite = ctl_q[0];
  assign aluctl   = aluctl_q;
  assign result   = result_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_mips_decode_exec.sv
// Scoreboard bench for mips_decode_exec: the driver queues hand-computed expectations,
// the monitor pops and compares one per cycle after the output registers update.
module tb_mips_decode_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic [31:0] a, b;
  logic        bubble;
  logic        regdst, memread, memwrite, memtoreg, alusrc, regwrite, zero;
  logic [1:0]  branch, aluop;
  logic [3:0]  aluctl;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  bit done = 1'b0;

  typedef struct {
    string       name;
    logic [9:0]  ctl;
    logic [3:0]  aluctl;
    logic [31:0] result;
    logic        zero;
  } exp_t;

  exp_t sb[$];

  mips_decode_exec #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .a(a), .b(b),
    .bubble(bubble), .regdst(regdst), .branch(branch), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .aluop(aluop), .alusrc(alusrc),
    .regwrite(regwrite), .aluctl(aluctl), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic issue(input string nm, input logic rst, input logic bub,
                       input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [9:0] ectl, input logic [3:0] ealu,
                       input logic [31:0] eres, input logic ez);
    exp_t e;
    @(negedge clk);
    rst_n  = rst;
    bubble = bub;
    opcode = op;
    funct  = fn;
    a      = av;
    b      = bv;
    e.name = nm; e.ctl = ectl; e.aluctl = ealu; e.result = eres; e.zero = ez;
    sb.push_back(e);
  endtask

  // Monitor: compares each queued expectation just after the edge that captured its inputs.
  initial begin
    exp_t e;
    logic [9:0] ctl_act;
    while (!(done && sb.size() == 0)) begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        ctl_act = {regdst, branch, memread, memtoreg, aluop, memwrite, alusrc, regwrite};
        checks++;
        if (ctl_act !== e.ctl) begin
          errors++;
          $display("FAIL %s ctl: got %b expected %b", e.name, ctl_act, e.ctl);
        end
        checks++;
        if (aluctl !== e.aluctl) begin
          errors++;
          $display("FAIL %s aluctl: got %b expected %b", e.name, aluctl, e.aluctl);
        end
        checks++;
        if (result !== e.result) begin
          errors++;
          $display("FAIL %s result: got %h expected %h", e.name, result, e.result);
        end
        checks++;
        if (zero !== e.zero) begin
          errors++;
          $display("FAIL %s zero: got %b expected %b", e.name, zero, e.zero);
        end
      end
    end
  end

  localparam logic [9:0] C_R   = 10'b1_00_0_0_10_0_0_1;
  localparam logic [9:0] C_LW  = 10'b0_00_1_1_00_0_1_1;
  localparam logic [9:0] C_SW  = 10'b0_00_0_0_00_1_1_0;
  localparam logic [9:0] C_BEQ = 10'b0_01_0_0_01_0_0_0;
  localparam logic [9:0] C_BNE = 10'b0_10_0_0_01_0_0_0;

  initial begin
    int guard;
    rst_n = 1'b0; bubble = 1'b0; opcode = 6'h23; funct = 6'h00; a = 32'd5; b = 32'd3;

    issue("reset0", 0, 0, 6'h23, 6'h00, 32'd5, 32'd3, 10'b0, 4'b0000, 32'd0, 1'b0);
    issue("reset1", 0, 1, 6'h23, 6'h00, 32'd5, 32'd3, 10'b0, 4'b0000, 32'd0, 1'b0);
    issue("lw_release", 1, 0, 6'h23, 6'h00, 32'd5, 32'd3, C_LW, 4'b0010, 32'd8, 1'b0);

    issue("r_add", 1, 0, 6'h00, 6'h20, 32'hC, 32'hA, C_R, 4'b0010, 32'h16, 1'b0);
    issue("r_sub", 1, 0, 6'h00, 6'h22, 32'hC, 32'hA, C_R, 4'b0110, 32'h2, 1'b0);
    issue("r_and", 1, 0, 6'h00, 6'h24, 32'hC, 32'hA, C_R, 4'b0000, 32'h8, 1'b0);
    issue("r_or",  1, 0, 6'h00, 6'h25, 32'hC, 32'hA, C_R, 4'b0001, 32'hE, 1'b0);
    issue("r_nor", 1, 0, 6'h00, 6'h27, 32'hC, 32'hA, C_R, 4'b1100, 32'hFFFFFFF1, 1'b0);
    issue("r_slt", 1, 0, 6'h00, 6'h2A, 32'hC, 32'hA, C_R, 4'b0111, 32'h0, 1'b1);

    issue("slt_signed", 1, 0, 6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, C_R, 4'b0111, 32'd1, 1'b0);
    issue("add_wrap",   1, 0, 6'h00, 6'h20, 32'hFFFFFFFF, 32'd1, C_R, 4'b0010, 32'd0, 1'b1);

    issue("beq", 1, 0, 6'h04, 6'h00, 32'h1234, 32'h1234, C_BEQ, 4'b0110, 32'd0, 1'b1);
    issue("bne", 1, 0, 6'h05, 6'h00, 32'd7, 32'd3, C_BNE, 4'b0110, 32'd4, 1'b0);

    issue("sw_bubble", 1, 1, 6'h2B, 6'h00, 32'h100, 32'h10, 10'b0, 4'b0010, 32'h110, 1'b0);
    issue("sw",        1, 0, 6'h2B, 6'h00, 32'h100, 32'h10, C_SW, 4'b0010, 32'h110, 1'b0);

    issue("bad_opcode", 1, 0, 6'h3F, 6'h00, 32'd1, 32'd2, 10'b0, 4'b0010, 32'd3, 1'b0);
    issue("bad_funct",  1, 0, 6'h00, 6'h3F, 32'd5, 32'd6, C_R, 4'b1111, 32'd0, 1'b1);

    done = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
